// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Used by reset_seq for its state encoding and counter/index widths.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        DONE    = 2'd2
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // $clog2 of 1 is 0; registers still need at least one bit
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reset_seq_sync_n.sv
// Async-set, sync-release reset synchronizer chain of STAGES flops.
// Reusable on any reset path that crosses into the clk domain.
module sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_s
);

    logic [STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_pipe <= '1;
        else       sync_pipe <= {sync_pipe[STAGES-2:0], 1'b0};
    end

    assign rst_s = sync_pipe[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset synchronizer + sequencer: asserts all channels asynchronously, then
// releases them in order (bit 0 first) after a hold time, with a fixed gap.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_released,
    output logic              busy
);

    localparam int CNT_W = clog2_min1(max2(HOLD_CYCLES, GAP_CYCLES));
    localparam int CH_W  = clog2_min1(NUM_CH);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    logic rst_s;

    sync_n #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .rst_s (rst_s)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              all_rel_q, busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_q     <= '1;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            rst_q     <= rst_d;
            all_rel_q <= (state_d == DONE);
            busy_q    <= (state_d != DONE);
        end
    end

    // ch_q holds the index of the next channel to release while in STAGGER
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        if (sw_rst_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            ch_d    = '0;
            rst_d   = '1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (!rst_s) begin
                        if (cnt_q == HOLD_LAST) begin
                            rst_d[0] = 1'b0;
                            cnt_d    = '0;
                            ch_d     = CH_W'(1);
                            state_d  = (NUM_CH == 1) ? DONE : STAGGER;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                STAGGER: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        for (int i = 0; i < NUM_CH; i++)
                            if (ch_q == CH_W'(i)) rst_d[i] = 1'b0;
                        if (ch_q == CH_LAST) state_d = DONE;
                        else                 ch_d    = ch_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE:    ;
                default: state_d = HOLD;
            endcase
        end
    end

    assign rst_out      = rst_q;
    assign all_released = all_rel_q;
    assign busy         = busy_q;

endmodule
